// File: rtl/pipelined_kogge_stone_adder_if.sv
// Valid/ready operand and result bus for the pipelined Kogge-Stone adder.
// The adder takes the slave side; producers and consumers take the master side.
interface pipelined_kogge_stone_adder_if #(
  parameter int unsigned N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_kogge_stone_adder.sv
// Pipelined N-bit Kogge-Stone adder/subtractor with valid/ready flow control.
// Carry-in is pre-merged into bit 0 so K prefix levels resolve every carry.
module pipelined_kogge_stone_adder #(
  parameter int unsigned N         = 32,
  parameter int unsigned REG_EVERY = 1
) (
  input logic                          clk,
  input logic                          reset,
  pipelined_kogge_stone_adder_if.slave bus
);
  localparam int unsigned K  = $clog2(N);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned RE = (REG_EVERY == 0) ? 1 : REG_EVERY;
  localparam int unsigned NS = (K - 1) / RE;

  if ((N < 4) || (N > 64) || ((N & (N - 1)) != 0)) begin : g_bad_n
    $error("pipelined_kogge_stone_adder: N must be a power of 2 in 4..64");
  end
  if ((REG_EVERY < 1) || (REG_EVERY > K)) begin : g_bad_reg_every
    $error("pipelined_kogge_stone_adder: REG_EVERY must be in 1..log2(N)");
  end

  typedef struct packed {
    logic         v;
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N-1:0] p0;
    logic         c0;
    logic         sa;
  } stage_t;

  // Group generate after one prefix level of span 2^(lvl-1).
  function automatic logic [N-1:0] ks_g(logic [N-1:0] g, logic [N-1:0] p, int unsigned lvl);
    logic [N-1:0] o;
    int unsigned  d;
    d = 32'd1 << (lvl - 32'd1);
    o = g;
    for (int unsigned e = d; e < N; e++) begin
      o[IW'(e)] = g[IW'(e)] | (p[IW'(e)] & g[IW'(e - d)]);
    end
    return o;
  endfunction

  function automatic logic [N-1:0] ks_p(logic [N-1:0] p, int unsigned lvl);
    logic [N-1:0] o;
    int unsigned  d;
    d = 32'd1 << (lvl - 32'd1);
    o = p;
    for (int unsigned e = d; e < N; e++) begin
      o[IW'(e)] = p[IW'(e)] & p[IW'(e - d)];
    end
    return o;
  endfunction

  logic         w_adv;
  logic [N-1:0] w_beff;
  stage_t       w_in;
  logic [N-1:0] w_sum;
  logic         w_cout;
  logic         w_ovf;

  logic         r_out_valid;
  logic [N-1:0] r_sum;
  logic         r_cout;
  logic         r_ovf;

  assign w_adv        = bus.out_ready | ~r_out_valid;
  assign bus.in_ready = w_adv;

  // Bitwise P/G with the carry-in folded into bit 0 as a gray cell.
  always_comb begin
    w_beff    = bus.sub ? ~bus.b : bus.b;
    w_in.v    = bus.in_valid;
    w_in.c0   = bus.sub | bus.cin;
    w_in.sa   = bus.a[N-1];
    w_in.p0   = bus.a ^ w_beff;
    w_in.g    = bus.a & w_beff;
    w_in.g[0] = w_in.g[0] | (w_in.p0[0] & w_in.c0);
    w_in.p    = w_in.p0;
    w_in.p[0] = 1'b0;
  end

  for (genvar s = 0; s <= NS; s++) begin : g_stg
    localparam int unsigned LO = s * RE + 1;
    localparam int unsigned HI = (s == NS) ? K : (s + 1) * RE;

    stage_t       w_src;
    stage_t       r_stg;
    logic [N-1:0] w_g;
    logic [N-1:0] w_p;

    if (s == 0) begin : g_head
      assign w_src = w_in;
    end else begin : g_link
      assign w_src = g_stg[s-1].g_fwd.w_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_stg <= '0;
      end else if (w_adv) begin
        r_stg <= w_src;
      end
    end

    always_comb begin
      w_g = r_stg.g;
      w_p = r_stg.p;
      for (int unsigned j = LO; j <= HI; j++) begin
        w_g = ks_g(w_g, w_p, j);
        w_p = ks_p(w_p, j);
      end
    end

    if (s < NS) begin : g_fwd
      stage_t w_nxt;
      always_comb begin
        w_nxt    = r_stg;
        w_nxt.g  = w_g;
        w_nxt.p  = w_p;
      end
    end
  end

  // Resolved carries: w_g[i] is the carry out of bit i.
  always_comb begin
    w_sum  = g_stg[NS].r_stg.p0 ^ {g_stg[NS].w_g[N-2:0], g_stg[NS].r_stg.c0};
    w_cout = g_stg[NS].w_g[N-1];
    w_ovf  = ~g_stg[NS].r_stg.p0[N-1] & (w_sum[N-1] ^ g_stg[NS].r_stg.sa);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= g_stg[NS].r_stg.v;
      r_sum       <= w_sum;
      r_cout      <= w_cout;
      r_ovf       <= w_ovf;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_pipelined_kogge_stone_adder.sv
// Scoreboard bench for pipelined_kogge_stone_adder in three configurations:
// (N=32,RE=1,LAT=6), (N=8,RE=3,LAT=2), (N=64,RE=2,LAT=4).
module tb_pipelined_kogge_stone_adder;
  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          exp_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   rnd_mode = 1'b0;
  exp_t q8[$];
  exp_t q32[$];
  exp_t q64[$];
  logic        prev_stall = 1'b0;
  logic [63:0] prev_sum = '0;

  pipelined_kogge_stone_adder_if #(.N(8))  if8 ();
  pipelined_kogge_stone_adder_if #(.N(32)) if32 ();
  pipelined_kogge_stone_adder_if #(.N(64)) if64 ();

  pipelined_kogge_stone_adder #(.N(8),  .REG_EVERY(3)) u_dut8  (.clk(clk), .reset(reset), .bus(if8));
  pipelined_kogge_stone_adder #(.N(32), .REG_EVERY(1)) u_dut32 (.clk(clk), .reset(reset), .bus(if32));
  pipelined_kogge_stone_adder #(.N(64), .REG_EVERY(2)) u_dut64 (.clk(clk), .reset(reset), .bus(if64));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rnd_mode) if32.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(int w, logic [63:0] a, logic [63:0] b, logic cin, logic sub, int expc);
    exp_t        e;
    logic [64:0] mask;
    logic [64:0] t;
    logic [63:0] am, bm, s;
    mask = (65'd1 << w) - 65'd1;
    am   = a & mask[63:0];
    bm   = b & mask[63:0];
    if (sub) begin
      s      = (am - bm) & mask[63:0];
      e.cout = (am >= bm);
      e.ovf  = (am[w-1] != bm[w-1]) && (s[w-1] != am[w-1]);
    end else begin
      t      = {1'b0, am} + {1'b0, bm} + {64'd0, cin};
      s      = t[63:0] & mask[63:0];
      e.cout = t[w];
      e.ovf  = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    end
    e.sum     = s;
    e.exp_cyc = expc;
    return e;
  endfunction

  function automatic int lat_of(int w);
    return (w == 8) ? 2 : (w == 32) ? 6 : 4;
  endfunction

  function automatic logic rdy(int w);
    return (w == 8) ? if8.in_ready : (w == 32) ? if32.in_ready : if64.in_ready;
  endfunction

  task automatic drive(int w, logic v, logic [63:0] a, logic [63:0] b, logic cin, logic sub);
    case (w)
      8:       begin if8.in_valid = v;  if8.a = a[7:0];   if8.b = b[7:0];   if8.cin = cin;  if8.sub = sub;  end
      32:      begin if32.in_valid = v; if32.a = a[31:0]; if32.b = b[31:0]; if32.cin = cin; if32.sub = sub; end
      default: begin if64.in_valid = v; if64.a = a;       if64.b = b;       if64.cin = cin; if64.sub = sub; end
    endcase
  endtask

  // Drive one beat at posedge+1 and push its expectation once acceptance is certain.
  task automatic send(int w, logic [63:0] a, logic [63:0] b, logic cin, logic sub, bit latchk);
    bit   done = 1'b0;
    exp_t e;
    @(posedge clk); #1;
    drive(w, 1'b1, a, b, cin, sub);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (rdy(w)) begin
        e = model(w, a, b, cin, sub, latchk ? cyc + lat_of(w) : -1);
        if (w == 8) q8.push_back(e);
        else if (w == 32) q32.push_back(e);
        else q64.push_back(e);
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) check_eq("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    if8.in_valid  = 1'b0;
    if32.in_valid = 1'b0;
    if64.in_valid = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while ((q8.size() + q32.size() + q64.size()) != 0 && i < 300) begin
      @(negedge clk);
      i++;
    end
    check_eq("drain", 64'(q8.size() + q32.size() + q64.size()), 64'd0);
  endtask

  task automatic run_dir(int w);
    logic [64:0] m;
    logic [63:0] ones, maxp;
    m    = (65'd1 << w) - 65'd1;
    ones = m[63:0];
    maxp = ones >> 1;
    send(w, 64'd25, 64'd75, 1'b0, 1'b0, 1'b1);
    send(w, ones, 64'd0, 1'b1, 1'b0, 1'b0);
    send(w, maxp, 64'd1, 1'b0, 1'b0, 1'b0);
    send(w, 64'd10, 64'd3, 1'b1, 1'b1, 1'b0);
    send(w, 64'd3, 64'd10, 1'b0, 1'b1, 1'b0);
    send(w, maxp + 64'd1, 64'd1, 1'b0, 1'b1, 1'b0);
    if (w == 8) send(w, 64'hC8, 64'h64, 1'b0, 1'b0, 1'b0);
    idle();
    drain();
  endtask

  task automatic mon(int w, logic ov, logic ordy, logic [63:0] s, logic co, logic of);
    exp_t e;
    int   sz;
    if (!(ov && ordy)) return;
    sz = (w == 8) ? q8.size() : (w == 32) ? q32.size() : q64.size();
    if (sz == 0) begin
      check_eq($sformatf("spurious_out%0d", w), 64'(ov), 64'd0);
      return;
    end
    if (w == 8) e = q8.pop_front();
    else if (w == 32) e = q32.pop_front();
    else e = q64.pop_front();
    check_eq($sformatf("sum%0d", w), s, e.sum);
    check_eq($sformatf("cout%0d", w), 64'(co), 64'(e.cout));
    check_eq($sformatf("ovf%0d", w), 64'(of), 64'(e.ovf));
    if (e.exp_cyc >= 0) check_eq($sformatf("latency%0d", w), 64'(cyc), 64'(e.exp_cyc));
  endtask

  always @(negedge clk) begin
    logic exp_rdy;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      exp_rdy = if32.out_ready | ~if32.out_valid;
      check_eq("in_ready32", 64'(if32.in_ready), 64'(exp_rdy));
      if (prev_stall) begin
        check_eq("hold_valid32", 64'(if32.out_valid), 64'd1);
        check_eq("hold_sum32", 64'(if32.sum), prev_sum);
      end
      prev_stall = if32.out_valid & ~if32.out_ready;
      prev_sum   = 64'(if32.sum);
      mon(8,  if8.out_valid,  if8.out_ready,  64'(if8.sum),  if8.cout,  if8.ovf);
      mon(32, if32.out_valid, if32.out_ready, 64'(if32.sum), if32.cout, if32.ovf);
      mon(64, if64.out_valid, if64.out_ready, 64'(if64.sum), if64.cout, if64.ovf);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(8, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(32, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(64, 1'b0, '0, '0, 1'b0, 1'b0);
    if8.out_ready  = 1'b1;
    if32.out_ready = 1'b1;
    if64.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid32", 64'(if32.out_valid), 64'd0);
    check_eq("rst_sum32", 64'(if32.sum), 64'd0);
    check_eq("rst_cout32", 64'(if32.cout), 64'd0);
    check_eq("rst_ovf32", 64'(if32.ovf), 64'd0);
    check_eq("rst_in_ready32", 64'(if32.in_ready), 64'd1);
    check_eq("rst_out_valid8", 64'(if8.out_valid), 64'd0);
    check_eq("rst_out_valid64", 64'(if64.out_valid), 64'd0);
    @(posedge clk); #3;
    reset = 1'b0;

    run_dir(32);
    run_dir(8);
    run_dir(64);

    // Back-to-back random stream against a randomly stalling consumer.
    rnd_mode = 1'b1;
    for (int i = 0; i < 100; i++) begin
      send(32, {$urandom, $urandom}, {$urandom, $urandom},
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    idle();
    rnd_mode = 1'b0;
    @(posedge clk); #2;
    if32.out_ready = 1'b1;
    drain();

    // Reset with three beats held in a stalled pipeline.
    @(posedge clk); #2;
    if32.out_ready = 1'b0;
    send(32, 64'd1, 64'd2, 1'b0, 1'b0, 1'b0);
    send(32, 64'd3, 64'd4, 1'b0, 1'b0, 1'b0);
    send(32, 64'd5, 64'd6, 1'b0, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 30 && !if32.out_valid; i++) @(negedge clk);
    check_eq("stalled_valid32", 64'(if32.out_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst_valid32", 64'(if32.out_valid), 64'd0);
    check_eq("async_rst_sum32", 64'(if32.sum), 64'd0);
    q32.delete();
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b0;
    if32.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    send(32, 64'h1234_5678, 64'h0FED_CBA9, 1'b1, 1'b0, 1'b1);
    idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
